// File: rtl/mcpu_pkg.sv
// mcpu_pkg: opcodes, FSM states and ALU control for the multicycle core.
// Shared by mcpu_alu and mcpu_core.
package mcpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  function automatic logic [2:0] alu_ctl(input logic [3:0] op);
    logic [2:0] c;
    case (op)
      OP_AND:  c = ALU_AND;
      OP_OR:   c = ALU_OR;
      OP_SUB:  c = ALU_SUB;
      OP_SLT:  c = ALU_SLT;
      OP_BEQ:  c = ALU_SUB;
      OP_BNE:  c = ALU_SUB;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

  function automatic logic op_valid(input logic [3:0] op);
    return op <= OP_BNE;
  endfunction

  function automatic logic is_rtype(input logic [3:0] op);
    return (op <= OP_OR) || (op == OP_SLT);
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_mem(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mcpu_alu.sv
// mcpu_alu: combinational DATA_W ALU with zero flag.
// Control encoding comes from mcpu_pkg.
import mcpu_pkg::*;

module mcpu_alu #(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        ctl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              zero
);

  logic lt;
  assign lt = $signed(a) < $signed(b);

  // Select the operation; unknown codes yield zero.
  always_comb begin
    y = '0;
    case (ctl)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {{(DATA_W-1){1'b0}}, lt};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/mcpu_core.sv
// mcpu_core: multicycle 16-bit-ISA core, one shared req/ready memory port.
// Define MCPU_TRAP_EN to halt on undefined opcodes (else they are NOPs).
import mcpu_pkg::*;

module mcpu_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted
);

`ifdef MCPU_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t            state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] rf [4];
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] mdr;
  logic [ADDR_W-1:0] pc2;
  logic [ADDR_W-1:0] tgt;

  logic [3:0]        op;
  logic [1:0]        rs;
  logic [1:0]        rt;
  logic [1:0]        rd;
  logic [7:0]        imm;

  assign op  = ir[15:12];
  assign rs  = ir[11:10];
  assign rt  = ir[9:8];
  assign rd  = ir[7:6];
  assign imm = ir[7:0];

  logic [DATA_W-1:0] imm_d;
  logic [ADDR_W-1:0] imm_a;
  logic [ADDR_W-1:0] pc_inc;

  assign imm_d  = {{(DATA_W-8){imm[7]}}, imm};
  assign imm_a  = {{(ADDR_W-9){imm[7]}}, imm, 1'b0};
  assign pc_inc = pc + ADDR_W'(2);

  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic              alu_zero;
  logic              taken;
  logic [ADDR_W-1:0] nxt;

  assign alu_b = (is_rtype(op) || is_branch(op)) ? b : imm_d;

  mcpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .ctl  (alu_ctl(op)),
    .a    (a),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

  assign taken = (op == OP_BEQ) ? alu_zero : !alu_zero;
  assign nxt   = taken ? tgt : pc2;

  logic [1:0]        wb_dst;
  logic [DATA_W-1:0] wb_val;

  assign wb_dst = is_rtype(op) ? rd : rt;
  assign wb_val = (op == OP_LW) ? mdr : alu_out;

  // Retire marks the final cycle; memory-completing ops depend on ready.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_DECODE: retire = !op_valid(op) && !TRAP_EN;
      S_EXEC:   retire = is_branch(op);
      S_MEM:    retire = mem_req && mem_we && mem_ready;
      S_WB:     retire = 1'b1;
      default:  retire = 1'b0;
    endcase
  end

`ifdef MCPU_TRAP_EN
  assign halted = (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

  // Register file: r0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else if (state == S_WB && wb_dst != 2'd0) begin
      rf[wb_dst] <= wb_val;
    end
  end

  // Main FSM with registered memory-port outputs and PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      pc2       <= '0;
      tgt       <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          // Out of reset the request is raised one cycle late.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ready) begin
            ir      <= mem_rdata[15:0];
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a   <= rf[rs];
          b   <= rf[rt];
          pc2 <= pc_inc;
          tgt <= pc_inc + imm_a;
          if (op_valid(op)) begin
            state <= S_EXEC;
          end else if (TRAP_EN) begin
            state <= S_HALT;
          end else begin
            pc       <= pc_inc;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc_inc;
            state    <= S_FETCH;
          end
        end
        S_EXEC: begin
          alu_out <= alu_y;
          if (is_branch(op)) begin
            pc       <= nxt;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= nxt;
            state    <= S_FETCH;
          end else if (is_mem(op)) begin
            mem_req   <= 1'b1;
            mem_we    <= (op == OP_SW);
            mem_addr  <= ADDR_W'(alu_y);
            mem_wdata <= b;
            state     <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (mem_we) begin
              pc       <= pc2;
              mem_we   <= 1'b0;
              mem_addr <= pc2;
              state    <= S_FETCH;
            end else begin
              mdr     <= mem_rdata;
              mem_req <= 1'b0;
              state   <= S_WB;
            end
          end
        end
        S_WB: begin
          pc       <= pc2;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc2;
          state    <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule
